// File: rtl/sseg_formatter_if.sv
// sseg_formatter_if: producer handshake plus the num/dig_en/dp_en bus that feeds the
// seven-segment controller
interface sseg_formatter_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic [3:0]  in_dp;
   logic        busy;
   logic [13:0] num;
   logic [3:0]  dig_en;
   logic [3:0]  dp_en;
   logic        ovf;
   modport master (output in_valid, in_value, in_dp, input in_ready, busy, num, dig_en, dp_en, ovf);
   modport slave (input in_valid, in_value, in_dp, output in_ready, busy, num, dig_en, dp_en, ovf);
endinterface

// File: rtl/sseg_formatter.sv
// sseg_formatter: saturates a binary value, finds leading-zero blanking with one threshold
// compare per cycle, then updates the display bus atomically five edges after transfer
module sseg_formatter #(
   parameter int MAX_VAL       = 9999,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic             clk,
   input logic             rst,
   sseg_formatter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLAMP, CMP3, CMP2, CMP1, UPDATE} state_t;
   state_t      state;
   logic [15:0] val;
   logic [3:0]  dp;
   logic [2:0]  ndig;
   logic        ovf_pend;
   logic [3:0]  lead;
   logic [3:0]  dp_mask;
   // ndig is always 1..4 by the time UPDATE uses lead
   assign lead     = 4'b1111 >> (3'd4 - ndig);
   assign dp_mask  = dp[3] ? 4'b1111 : dp[2] ? 4'b0111 : dp[1] ? 4'b0011 : {3'b000, dp[0]};
   assign bus.in_ready = state == IDLE;
   assign bus.busy     = state != IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         val        <= '0;
         dp         <= '0;
         ndig       <= '0;
         ovf_pend   <= 1'b0;
         bus.num    <= '0;
         bus.dig_en <= 4'b0001;
         bus.dp_en  <= '0;
         bus.ovf    <= 1'b0;
      end else
         case (state)
            IDLE:
               if (bus.in_valid) begin
                  val   <= bus.in_value;
                  dp    <= bus.in_dp;
                  state <= CLAMP;
               end
            CLAMP: begin
               ovf_pend <= val > 16'(MAX_VAL);
               if (val > 16'(MAX_VAL)) val <= 16'(MAX_VAL);
               state <= CMP3;
            end
            CMP3: begin
               ndig  <= val >= 16'd1000 ? 3'd4 : 3'd0;
               state <= CMP2;
            end
            CMP2: begin
               if (ndig == 3'd0 && val >= 16'd100) ndig <= 3'd3;
               state <= CMP1;
            end
            CMP1: begin
               if (ndig == 3'd0) ndig <= val >= 16'd10 ? 3'd2 : 3'd1;
               state <= UPDATE;
            end
            UPDATE: begin
               bus.num    <= val[13:0];
               bus.dig_en <= BLANK_LEADING ? (lead | dp_mask) : 4'b1111;
               bus.dp_en  <= dp;
               bus.ovf    <= ovf_pend;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule
